// File: rtl/icache_tag_ctrl_pkg.sv
// Shared definitions for the I-cache tag-valid controller: widths, FSM states, tag compare.
package icache_tag_ctrl_pkg;
   localparam int TAG_WIDTH   = 20;
   localparam int INDEX_WIDTH = 6;
   localparam int TAGV_WIDTH  = TAG_WIDTH + 1;
   localparam int NUM_SETS    = 2 ** INDEX_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_MISS_REQ,
      ST_MISS_WAIT,
      ST_REFILL,
      ST_REPLAY,
      ST_IBAR
   } state_t;

   // Entry layout is {valid, tag}; an invalid entry never hits.
   function automatic logic tagv_hit(input logic [TAGV_WIDTH-1:0] entry,
                                     input logic [TAG_WIDTH-1:0]  ptag);
      return entry[TAG_WIDTH] && (entry[TAG_WIDTH-1:0] == ptag);
   endfunction
endpackage

// File: rtl/icache_tag_ctrl_if.sv
// Request/response, IBAR, refill and tagv-array signals of the tag controller.
interface icache_tag_ctrl_if;
   import icache_tag_ctrl_pkg::*;

   logic                             req_valid;
   logic                             req_ready;
   logic [INDEX_WIDTH-1:0]           req_index;
   logic [TAG_WIDTH-1:0]             req_ptag;
   logic                             resp_valid;
   logic                             resp_way;
   logic                             ibar_req;
   logic                             ibar_done;
   logic                             refill_valid;
   logic                             refill_ready;
   logic [TAG_WIDTH+INDEX_WIDTH-1:0] refill_addr;
   logic                             refill_done;
   logic [INDEX_WIDTH-1:0]           tagv_raddr;
   logic [INDEX_WIDTH-1:0]           tagv_waddr;
   logic [TAGV_WIDTH-1:0]            tagv_din;
   logic [1:0]                       tagv_we;
   logic                             tagv_ibar;
   logic [TAGV_WIDTH-1:0]            tagv_dout0;
   logic [TAGV_WIDTH-1:0]            tagv_dout1;

   modport master (
      input  req_valid, req_index, req_ptag, ibar_req, refill_ready, refill_done,
             tagv_dout0, tagv_dout1,
      output req_ready, resp_valid, resp_way, ibar_done, refill_valid, refill_addr,
             tagv_raddr, tagv_waddr, tagv_din, tagv_we, tagv_ibar
   );

   modport slave (
      output req_valid, req_index, req_ptag, ibar_req, refill_ready, refill_done,
             tagv_dout0, tagv_dout1,
      input  req_ready, resp_valid, resp_way, ibar_done, refill_valid, refill_addr,
             tagv_raddr, tagv_waddr, tagv_din, tagv_we, tagv_ibar
   );
endinterface

// File: rtl/icache_tag_ctrl_lru.sv
// One LRU bit per set: combinational read, single write port, synchronous clear.
module icache_lru_table
   import icache_tag_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   i_clr,
   input  logic                   i_we,
   input  logic [INDEX_WIDTH-1:0] i_waddr,
   input  logic                   i_wdata,
   input  logic [INDEX_WIDTH-1:0] i_raddr,
   output logic                   o_rdata
);
   logic [NUM_SETS-1:0] r_lru;

   always_ff @(posedge clk) begin
      if (!rstn || i_clr) begin
         r_lru <= '0;
      end else if (i_we) begin
         r_lru[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_lru[i_raddr];
endmodule

// File: rtl/icache_tag_ctrl.sv
// Two-way I-cache tag lookup/refill controller with IBAR invalidation and per-set LRU.
module icache_tag_ctrl
   import icache_tag_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   icache_tag_ctrl_if.master bus
);
   state_t                 r_state;
   logic [INDEX_WIDTH-1:0] r_index;
   logic [TAG_WIDTH-1:0]   r_ptag;
   logic                   r_victim;

   logic w_hit0, w_hit1, w_hit, w_hit_way, w_victim;
   logic w_accept, w_lru_rd, w_lru_we, w_lru_clr;

   assign w_hit0    = tagv_hit(bus.tagv_dout0, r_ptag);
   assign w_hit1    = tagv_hit(bus.tagv_dout1, r_ptag);
   assign w_hit     = w_hit0 | w_hit1;
   assign w_hit_way = ~w_hit0;
   // Fill an empty way first; only evict by LRU when the set is full.
   assign w_victim  = !bus.tagv_dout0[TAG_WIDTH] ? 1'b0 :
                      !bus.tagv_dout1[TAG_WIDTH] ? 1'b1 : w_lru_rd;

   icache_lru_table u_lru (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (w_lru_clr),
      .i_we    (w_lru_we),
      .i_waddr (r_index),
      .i_wdata (~w_hit_way),
      .i_raddr (r_index),
      .o_rdata (w_lru_rd)
   );

   // Outputs are held low while reset is asserted.
   always_comb begin
      bus.req_ready    = 1'b0;
      bus.resp_valid   = 1'b0;
      bus.resp_way     = 1'b0;
      bus.ibar_done    = 1'b0;
      bus.refill_valid = 1'b0;
      bus.refill_addr  = {r_ptag, r_index};
      bus.tagv_raddr   = r_index;
      bus.tagv_waddr   = r_index;
      bus.tagv_din     = '0;
      bus.tagv_we      = 2'b00;
      bus.tagv_ibar    = 1'b0;
      w_lru_we         = 1'b0;
      w_lru_clr        = 1'b0;
      if (rstn) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.ibar_req) begin
                  bus.tagv_ibar = 1'b1;
                  w_lru_clr     = 1'b1;
               end else begin
                  bus.req_ready = 1'b1;
               end
            end
            ST_LOOKUP: begin
               if (w_hit) begin
                  bus.resp_valid = 1'b1;
                  bus.resp_way   = w_hit_way;
                  bus.req_ready  = 1'b1;
                  w_lru_we       = 1'b1;
               end
            end
            ST_MISS_REQ: bus.refill_valid = 1'b1;
            ST_REFILL: begin
               bus.tagv_we[r_victim] = 1'b1;
               bus.tagv_din          = {1'b1, r_ptag};
            end
            ST_IBAR:  bus.ibar_done = 1'b1;
            default: ;
         endcase
      end
      w_accept = bus.req_valid & bus.req_ready;
      if (w_accept) begin
         bus.tagv_raddr = bus.req_index;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= ST_IDLE;
         r_index  <= '0;
         r_ptag   <= '0;
         r_victim <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.ibar_req) begin
                  r_state <= ST_IBAR;
               end else if (w_accept) begin
                  r_index <= bus.req_index;
                  r_ptag  <= bus.req_ptag;
                  r_state <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (w_hit) begin
                  if (w_accept) begin
                     r_index <= bus.req_index;
                     r_ptag  <= bus.req_ptag;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_victim <= w_victim;
                  r_state  <= ST_MISS_REQ;
               end
            end
            ST_MISS_REQ:  if (bus.refill_ready) r_state <= ST_MISS_WAIT;
            ST_MISS_WAIT: if (bus.refill_done)  r_state <= ST_REFILL;
            // The array forwards the written entry, so REPLAY re-reads the same set.
            ST_REFILL:    r_state <= ST_REPLAY;
            ST_REPLAY:    r_state <= ST_LOOKUP;
            ST_IBAR:      r_state <= ST_IDLE;
            default:      r_state <= ST_IDLE;
         endcase
      end
   end
endmodule
